// File: rtl/osc_tri_squ_core.sv
// Note-driven oscillator: fetches a period word from the frequency ROM, divides clk by it and
// emits registered square/triangle samples. Define OSC_PWM_EN to add a pwm_duty input.
module osc_tri_squ_core #(
    parameter int unsigned PW = 16,
    parameter int unsigned AW = 7,
    parameter int unsigned OW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          note_req,
    input  logic [AW-1:0] note_idx,
    output logic          note_busy,
    output logic          note_ack,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [PW-1:0] rom_data,
`ifdef OSC_PWM_EN
    input  logic [OW-1:0] pwm_duty,
`endif
    output logic          osc_active,
    output logic [OW-1:0] sq_out,
    output logic [OW-1:0] tri_out
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rom_addr_q;
    logic          ack_q;

    logic [PW-1:0] pend_q;
    logic          pend_valid_q;

    logic [PW-1:0] cur_q, cur_d;
    logic [PW-1:0] tick_q, tick_d;
    logic [OW:0]   phase_q, phase_d;

    logic          running;
    logic          step;
    logic          load;

    logic          active_q;
    logic [OW-1:0] sq_q, sq_d;
    logic [OW-1:0] tri_q, tri_d;

    // ---------------------------------------------------------------------------------------
    // Fetch FSM
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (note_req) state_d = StFetch;
            StFetch: state_d = StWait;
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_q == StWait);
            if (state_q == StIdle && note_req) begin
                rom_addr_q <= note_idx;
            end
        end
    end

    assign note_busy = (state_q != StIdle);
    assign rom_en    = (state_q == StFetch);
    assign rom_addr  = rom_addr_q;
    assign note_ack  = ack_q;

    // ---------------------------------------------------------------------------------------
    // Pending period: a fresh fetch wins over a same-cycle load, so the newest note survives
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else if (state_q == StWait) begin
            pend_q       <= rom_data;
            pend_valid_q <= 1'b1;
        end else if (load) begin
            pend_valid_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Period divider and phase counter
    // ---------------------------------------------------------------------------------------
    assign running = (cur_q != '0);
    assign step    = running && (tick_q == '0);
    // Only swap periods at the phase wrap so no waveform segment is ever truncated
    assign load    = pend_valid_q && (!running || (step && (&phase_q)));

    always_comb begin
        cur_d   = cur_q;
        tick_d  = tick_q;
        phase_d = phase_q;

        if (running) begin
            if (tick_q == '0) begin
                tick_d  = cur_q - PW'(1);
                phase_d = phase_q + 1'b1;
            end else begin
                tick_d = tick_q - PW'(1);
            end
        end

        if (load) begin
            cur_d = pend_q;
            if (pend_q == '0) begin
                tick_d  = '0;
                phase_d = '0;
            end else if (running) begin
                tick_d = pend_q - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_q   <= '0;
            tick_q  <= '0;
            phase_q <= '0;
        end else begin
            cur_q   <= cur_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Sample generation, registered one cycle behind phase
    // ---------------------------------------------------------------------------------------
    always_comb begin
        sq_d  = '0;
        tri_d = '0;
        if (running) begin
            tri_d = phase_q[OW] ? ~phase_q[OW-1:0] : phase_q[OW-1:0];
`ifdef OSC_PWM_EN
            sq_d  = (phase_q[OW:1] < pwm_duty) ? {OW{1'b1}} : '0;
`else
            sq_d  = phase_q[OW] ? '0 : {OW{1'b1}};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q <= 1'b0;
            sq_q     <= '0;
            tri_q    <= '0;
        end else begin
            active_q <= running;
            sq_q     <= sq_d;
            tri_q    <= tri_d;
        end
    end

    assign osc_active = active_q;
    assign sq_out     = sq_q;
    assign tri_out    = tri_q;

endmodule

// File: tb/tb_osc_tri_squ_core.sv
// Directed bench for osc_tri_squ_core (default build, fixed 50% square) with a small ROM model.
module tb_osc_tri_squ_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic        note_req;
    logic [6:0]  note_idx;
    logic        note_busy;
    logic        note_ack;
    logic        rom_en;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        osc_active;
    logic [7:0]  sq_out;
    logic [7:0]  tri_out;

    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int ack_cnt = 0;

    osc_tri_squ_core #(
        .PW(16),
        .AW(7),
        .OW(8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .note_req   (note_req),
        .note_idx   (note_idx),
        .note_busy  (note_busy),
        .note_ack   (note_ack),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .osc_active (osc_active),
        .sq_out     (sq_out),
        .tri_out    (tri_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_lut(input logic [6:0] idx);
        case (idx)
            7'd69:   return 16'd916;
            7'd12:   return 16'd24660;
            7'd5:    return 16'd0;
            7'd3:    return 16'd2;
            7'd4:    return 16'd3;
            default: return 16'd10 + {9'd0, idx};
        endcase
    endfunction

    // Registered ROM: data valid the cycle after rom_en
    always @(posedge clk) begin
        if (!rstn) rom_data <= 16'd0;
        else if (rom_en) rom_data <= rom_lut(rom_addr);
    end

    always @(posedge clk) begin
        if (rom_en) en_cnt <= en_cnt + 1;
        if (note_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {sq_out, tri_out} expected while phase ph is on display (50% square)
    function automatic logic [15:0] phase_obs(input int ph);
        logic [8:0] p;
        p = ph[8:0];
        return p[8] ? {8'h00, ~p[7:0]} : {8'hFF, p[7:0]};
    endfunction

    task automatic wait_phase(input string tag, input int ph, input int limit);
        int n;
        n = 0;
        while ({sq_out, tri_out} !== phase_obs(ph) && n < limit) begin
            tick();
            n++;
        end
        check(tag, {16'd0, sq_out, tri_out}, {16'd0, phase_obs(ph)});
    endtask

    task automatic seg_len(output int len);
        logic [15:0] v;
        v = {sq_out, tri_out};
        len = 0;
        do begin
            tick();
            len++;
        end while ({sq_out, tri_out} == v && len < 30000);
    endtask

    task automatic request(input logic [6:0] idx);
        note_req = 1'b1;
        note_idx = idx;
        tick();
        note_req = 1'b0;
    endtask

    initial begin
        int en0, ack0, len, badseg, n;
        logic prev_sq;

        rstn = 1'b0;
        note_req = 1'b0;
        note_idx = 7'd0;
        tick();
        tick();
        check("rst_busy", note_busy, 0);
        check("rst_ack", note_ack, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_active", osc_active, 0);
        check("rst_sq", sq_out, 0);
        check("rst_tri", tri_out, 0);
        rstn = 1'b1;
        tick();

        // Note 69, with a competing request held during the busy window
        en0  = en_cnt;
        ack0 = ack_cnt;
        note_req = 1'b1;
        note_idx = 7'd69;
        tick();
        note_idx = 7'd12;
        check("fetch_rom_en", rom_en, 1);
        check("fetch_rom_addr", rom_addr, 69);
        check("fetch_busy", note_busy, 1);
        tick();
        note_req = 1'b0;
        check("wait_rom_en", rom_en, 0);
        check("wait_rom_addr", rom_addr, 69);
        check("wait_busy", note_busy, 1);
        tick();
        check("ack_pulse", note_ack, 1);
        check("ack_busy", note_busy, 0);
        tick();
        check("ack_gone", note_ack, 0);
        check("load_active", osc_active, 0);
        tick();
        check("run_active", osc_active, 1);
        check("run_sq", sq_out, 8'hFF);
        check("run_tri0", tri_out, 0);
        tick();
        check("run_tri1", tri_out, 1);
        repeat (915) tick();
        check("p916_hold", tri_out, 1);
        tick();
        check("p916_step", tri_out, 2);
        check("single_rom_en", en_cnt - en0, 1);
        check("single_ack", ack_cnt - ack0, 1);

        // Reset in the middle of a fetch
        note_req = 1'b1;
        note_idx = 7'd3;
        tick();
        note_req = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        check("midrst_busy", note_busy, 0);
        check("midrst_active", osc_active, 0);
        check("midrst_sq", sq_out, 0);
        ack0 = ack_cnt;
        repeat (5) tick();
        check("midrst_no_ack", ack_cnt - ack0, 0);
        check("midrst_muted", osc_active, 0);

        // P=2 running, switch to P=3 mid-cycle; change must land at the wrap
        request(7'd3);
        repeat (4) tick();
        wait_phase("reach_ph100", 100, 400);
        request(7'd4);
        repeat (4) tick();
        wait_phase("reach_ph110", 110, 100);
        badseg = 0;
        for (int ph = 110; ph <= 510; ph++) begin
            seg_len(len);
            if (len != 2) badseg++;
        end
        check("old_period_held", badseg, 0);
        seg_len(len);
        check("last_seg_full", len, 2);
        check("wrap_phase0", {16'd0, sq_out, tri_out}, {16'd0, phase_obs(0)});
        seg_len(len);
        check("new_period_seg0", len, 3);
        check("wrap_phase1", {16'd0, sq_out, tri_out}, {16'd0, phase_obs(1)});
        seg_len(len);
        check("new_period_seg1", len, 3);

        // Zero period from ROM: mute at the next wrap
        request(7'd5);
        n = 0;
        prev_sq = sq_out;
        while (osc_active === 1'b1 && n < 3000) begin
            prev_sq = sq_out[0];
            tick();
            n++;
        end
        check("zero_mute", osc_active, 0);
        check("zero_at_wrap", prev_sq, 0);
        check("zero_sq", sq_out, 0);
        check("zero_tri", tri_out, 0);
        repeat (10) tick();
        check("zero_stay_active", osc_active, 0);
        check("zero_stay_sq", sq_out, 0);
        check("zero_stay_tri", tri_out, 0);

        // Restart from muted loads immediately
        request(7'd4);
        tick();
        tick();
        check("restart_ack", note_ack, 1);
        tick();
        tick();
        check("restart_active", osc_active, 1);
        check("restart_sq", sq_out, 8'hFF);
        check("restart_tri", tri_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
